// File: rtl/frog_ctrl_if.sv
// frog_ctrl_if: frog controller bus; master = keyboard/game side, slave = frog_ctrl
interface frog_ctrl_if;
  logic [7:0] keycode;
  logic Car_Collision;
  logic [10:0] Frog_X;
  logic [10:0] Frog_Y;
  logic [1:0] Lives;
  logic Frog_Dead;
  logic win;
  logic lose;
  modport master (output keycode, Car_Collision, input Frog_X, Frog_Y, Lives, Frog_Dead, win, lose);
  modport slave (input keycode, Car_Collision, output Frog_X, Frog_Y, Lives, Frog_Dead, win, lose);
endinterface

// File: rtl/frog_ctrl.sv
// frog_ctrl: frog hop/death/win FSM; ports frame_clk, Reset, bus (keycode, Car_Collision in; Frog_X/Frog_Y/Lives/Frog_Dead/win/lose out)
module frog_ctrl #(
  parameter logic [10:0] START_X = 11'd300,
  parameter logic [10:0] START_Y = 11'd440,
  parameter logic [10:0] STEP = 11'd40,
  parameter logic [10:0] X_MAX = 11'd600,
  parameter logic [10:0] Y_MAX = 11'd440,
  parameter logic [5:0] HOP_FRAMES = 6'd8,
  parameter logic [5:0] DEAD_FRAMES = 6'd30,
  parameter logic [1:0] LIVES_INIT = 2'd3
) (
  input logic frame_clk,
  input logic Reset,
  frog_ctrl_if.slave bus
);
  localparam logic [7:0] KW = 8'h1A, KA = 8'h04, KS = 8'h16, KD = 8'h07;
  typedef enum logic [2:0] {IDLE, HOP, DEAD, WIN, LOSE} state_t;
  state_t state, state_n;
  logic [7:0] prev;
  logic [5:0] cnt, cnt_n;
  logic [10:0] hx, hy, x_n, y_n;
  logic [1:0] lives_n;
  logic press;
  always_comb begin
    press = state == IDLE && bus.keycode inside {KW, KA, KS, KD} && bus.keycode != prev;
    // bounds are tested before the subtraction/addition so nothing can wrap
    hx = (bus.keycode == KA && bus.Frog_X >= STEP) ? bus.Frog_X - STEP :
         (bus.keycode == KD && ({1'b0, bus.Frog_X} + {1'b0, STEP}) <= {1'b0, X_MAX}) ? bus.Frog_X + STEP : bus.Frog_X;
    hy = (bus.keycode == KW && bus.Frog_Y >= STEP) ? bus.Frog_Y - STEP :
         (bus.keycode == KS && ({1'b0, bus.Frog_Y} + {1'b0, STEP}) <= {1'b0, Y_MAX}) ? bus.Frog_Y + STEP : bus.Frog_Y;
  end
  always_ff @(posedge frame_clk)
    if (Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.Car_Collision ? DEAD : press ? HOP : IDLE;
      HOP: state_n = bus.Car_Collision ? DEAD : bus.Frog_Y == 11'd0 ? WIN : cnt == HOP_FRAMES - 6'd1 ? IDLE : HOP;
      DEAD: state_n = cnt != DEAD_FRAMES - 6'd1 ? DEAD : bus.Lives != 2'd0 ? IDLE : LOSE;
      default: state_n = state;
    endcase
  end
  always_comb begin
    cnt_n = (state_n == state && (state == HOP || state == DEAD)) ? cnt + 6'd1 : 6'd0;
    x_n = (state == IDLE && state_n == HOP) ? hx : (state == DEAD && state_n == IDLE) ? START_X : bus.Frog_X;
    y_n = (state == IDLE && state_n == HOP) ? hy : (state == DEAD && state_n == IDLE) ? START_Y : bus.Frog_Y;
    lives_n = (state != DEAD && state_n == DEAD && bus.Lives != 2'd0) ? bus.Lives - 2'd1 : bus.Lives;
  end
  always_ff @(posedge frame_clk)
    if (Reset) begin
      cnt <= 6'd0;
      prev <= 8'h00;
      bus.Frog_X <= START_X;
      bus.Frog_Y <= START_Y;
      bus.Lives <= LIVES_INIT;
      bus.Frog_Dead <= 1'b0;
      bus.win <= 1'b0;
      bus.lose <= 1'b0;
    end else begin
      cnt <= cnt_n;
      prev <= bus.keycode;
      bus.Frog_X <= x_n;
      bus.Frog_Y <= y_n;
      bus.Lives <= lives_n;
      bus.Frog_Dead <= state_n == DEAD;
      bus.win <= state_n == WIN;
      bus.lose <= state_n == LOSE;
    end
endmodule

// File: tb/tb_frog_ctrl.sv
// tb_frog_ctrl: directed plus random checks of frog_ctrl against a frame-level game model
module tb_frog_ctrl;
  logic frame_clk = 1'b0;
  logic Reset = 1'b1;
  frog_ctrl_if bus();
  frog_ctrl dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus.slave));
  always #5 frame_clk = ~frame_clk;
  int total = 0, bad = 0;
  int mx, my, ml, mode, tmr, mprev;
  bit md, mw, mlo;
  localparam int M_IDLE = 0, M_HOP = 1, M_DEAD = 2, M_WIN = 3, M_LOSE = 4;
  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model(input logic [7:0] k, input bit c, input bit r);
    int dx, dy;
    if (r) begin
      mx = 300; my = 440; ml = 3; md = 0; mw = 0; mlo = 0; mode = M_IDLE; tmr = 0; mprev = 0;
      return;
    end
    if ((mode == M_IDLE || mode == M_HOP) && c) begin
      mode = M_DEAD; tmr = 30; md = 1; ml = ml > 0 ? ml - 1 : 0;
    end else if (mode == M_HOP) begin
      if (my == 0) begin mode = M_WIN; mw = 1; end
      else begin tmr--; if (tmr == 0) mode = M_IDLE; end
    end else if (mode == M_IDLE) begin
      if ((k == 8'h1A || k == 8'h04 || k == 8'h16 || k == 8'h07) && int'(k) != mprev) begin
        dx = k == 8'h04 ? -40 : k == 8'h07 ? 40 : 0;
        dy = k == 8'h1A ? -40 : k == 8'h16 ? 40 : 0;
        if (mx + dx >= 0 && mx + dx <= 600 && my + dy >= 0 && my + dy <= 440) begin
          mx += dx; my += dy;
        end
        mode = M_HOP; tmr = 8;
      end
    end else if (mode == M_DEAD) begin
      tmr--;
      if (tmr == 0) begin
        md = 0;
        if (ml > 0) begin mode = M_IDLE; mx = 300; my = 440; end
        else begin mode = M_LOSE; mlo = 1; end
      end
    end
    mprev = k;
  endtask
  task automatic tick(input logic [7:0] k, input bit c, input bit r);
    bus.keycode = k;
    bus.Car_Collision = c;
    Reset = r;
    @(posedge frame_clk);
    model(k, c, r);
    #1;
    chk("x", bus.Frog_X, mx);
    chk("y", bus.Frog_Y, my);
    chk("lives", bus.Lives, ml);
    chk("dead", bus.Frog_Dead, md);
    chk("win", bus.win, mw);
    chk("lose", bus.lose, mlo);
  endtask
  task automatic hop(input logic [7:0] k);
    tick(k, 0, 0);
    repeat (8) tick(8'h00, 0, 0);
  endtask
  logic [7:0] keys [6];
  initial begin
    keys = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h00, 8'h55};
    bus.keycode = 8'h00;
    bus.Car_Collision = 1'b0;
    tick(8'h00, 0, 1);
    chk("rst_x", bus.Frog_X, 300);
    chk("rst_y", bus.Frog_Y, 440);
    chk("rst_lives", bus.Lives, 3);
    tick(8'h1A, 0, 0);
    chk("w_y", bus.Frog_Y, 400);
    for (int i = 0; i < 8; i++) tick(i % 2 ? 8'h04 : 8'h07, 0, 0);
    chk("hop_lock_x", bus.Frog_X, 300);
    tick(8'h07, 0, 0);
    chk("after_hop_x", bus.Frog_X, 340);
    repeat (8) tick(8'h00, 0, 0);
    tick(8'h00, 0, 1);
    repeat (40) tick(8'h07, 0, 0);
    chk("held_d_x", bus.Frog_X, 340);
    tick(8'h00, 0, 1);
    repeat (9) hop(8'h04);
    chk("left_edge_x", bus.Frog_X, 20);
    tick(8'h16, 0, 0);
    chk("bottom_edge_y", bus.Frog_Y, 440);
    tick(8'h07, 0, 0);
    chk("bottom_hop_lock_x", bus.Frog_X, 20);
    repeat (8) tick(8'h00, 0, 0);
    repeat (16) hop(8'h07);
    chk("right_edge_x", bus.Frog_X, 580);
    tick(8'h00, 0, 1);
    tick(8'h1A, 1, 0);
    chk("coll_y", bus.Frog_Y, 440);
    chk("coll_lives", bus.Lives, 2);
    chk("coll_dead", bus.Frog_Dead, 1);
    repeat (29) tick(8'h00, 0, 0);
    chk("dead_hold", bus.Frog_Dead, 1);
    tick(8'h00, 0, 0);
    chk("respawn_dead", bus.Frog_Dead, 0);
    chk("respawn_x", bus.Frog_X, 300);
    repeat (2) begin
      tick(8'h00, 1, 0);
      repeat (30) tick(8'h00, 0, 0);
    end
    chk("lose_lives", bus.Lives, 0);
    chk("lose_flag", bus.lose, 1);
    hop(8'h1A);
    chk("lose_no_move", bus.Frog_Y, 440);
    tick(8'h00, 0, 1);
    repeat (11) hop(8'h1A);
    chk("win_y", bus.Frog_Y, 0);
    chk("win_flag", bus.win, 1);
    hop(8'h16);
    chk("win_no_move", bus.Frog_Y, 0);
    tick(8'h00, 0, 1);
    tick(8'h07, 1, 0);
    repeat (10) tick(8'h00, 0, 0);
    tick(8'h00, 0, 1);
    chk("mid_dead_rst_dead", bus.Frog_Dead, 0);
    chk("mid_dead_rst_lives", bus.Lives, 3);
    chk("mid_dead_rst_x", bus.Frog_X, 300);
    repeat (3000) tick(keys[$urandom_range(0, 5)], $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
